lin_map_seq: RTL



---
 rtl/lin_map_seq_if.sv | 38 +++
 rtl/lin_map_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lin_map_seq_if.sv
//==============================================================================
// Module      : lin_map_seq_if
// Description : Valid/ready bundle for lin_map_seq. Optional refresh-randomness
//               lane under LIN_MAP_REFRESH_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface lin_map_seq_if #(
  parameter int SHARES = 2,
  parameter int DW     = 8
);
  // With SHARES=1 the lane is one unused byte so its width stays legal.
  localparam int c_RW = (SHARES > 1) ? DW * (SHARES - 1) : DW;

  logic                   in_valid;
  logic                   in_ready;
  logic                   inv_i;
  logic [DW*SHARES-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW*SHARES-1:0]   out_data;
`ifdef LIN_MAP_REFRESH_EN
  logic [c_RW-1:0]        rnd_i;

  modport slave  (input  in_valid, inv_i, in_data, out_ready, rnd_i,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, inv_i, in_data, out_ready, rnd_i,
                  input  in_ready, out_valid, out_data);
`else
  modport slave  (input  in_valid, inv_i, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, inv_i, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
`endif
endinterface

`default_nettype wire

// File: rtl/lin_map_seq.sv
//==============================================================================
// Module      : lin_map_seq
// Description : Share-serial GF(2) basis change (forward/inverse 8x8 map) for
//               the masked AES S-box. Optional macro: LIN_MAP_REFRESH_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lin_map_seq #(
  parameter int SHARES = 2,
  parameter int DW     = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  lin_map_seq_if.slave   bus
);

  localparam int c_IW = (SHARES > 1) ? $clog2(SHARES) : 1;
  localparam int c_W  = DW * SHARES;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(SHARES - 1);

  if (DW != 8) begin : g_dw_check
    $error("lin_map_seq: DW must be 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_IW-1:0]   r_idx;
  logic [c_W-1:0]    r_in_data;
  logic [c_W-1:0]    r_out_data;
  logic              r_inv;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_last;
  logic [7:0]        w_share;
  logic [7:0]        w_mapped;
  logic [7:0]        w_fin;

  function automatic logic [7:0] f_fwd(input logic [7:0] a);
    logic [7:0] b;
    b[7] = a[7] ^ a[6] ^ a[5] ^ a[2] ^ a[1] ^ a[0];
    b[6] = a[6] ^ a[5] ^ a[4] ^ a[0];
    b[5] = a[6] ^ a[5] ^ a[1] ^ a[0];
    b[4] = a[7] ^ a[6] ^ a[5] ^ a[0];
    b[3] = a[7] ^ a[4] ^ a[3] ^ a[1] ^ a[0];
    b[2] = a[0];
    b[1] = a[6] ^ a[5] ^ a[0];
    b[0] = a[6] ^ a[3] ^ a[2] ^ a[1] ^ a[0];
    return b;
  endfunction

  function automatic logic [7:0] f_inv(input logic [7:0] b);
    logic [7:0] a;
    a[7] = b[4] ^ b[1];
    a[6] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[1] ^ b[0];
    a[5] = b[7] ^ b[6] ^ b[5] ^ b[3] ^ b[2] ^ b[0];
    a[4] = b[6] ^ b[1];
    a[3] = b[6] ^ b[5] ^ b[4] ^ b[3] ^ b[2] ^ b[1];
    a[2] = b[7] ^ b[5] ^ b[4] ^ b[1];
    a[1] = b[5] ^ b[1];
    a[0] = b[2];
    return a;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (r_idx == c_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          w_next     = bus.in_valid ? ST_BUSY : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept      = bus.in_valid & w_in_ready;
  assign w_last        = (r_state == ST_BUSY) && (r_idx == c_LAST);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;

  // Single matrix instance, time-shared across shares by the index mux.
  always_comb begin
    w_share = 8'h00;
    for (int k = 0; k < SHARES; k++) begin
      if (r_idx == c_IW'(k)) w_share = r_in_data[8*k +: 8];
    end
  end

  assign w_mapped = r_inv ? f_inv(w_share) : f_fwd(w_share);

`ifdef LIN_MAP_REFRESH_EN
  localparam int c_RW = (SHARES > 1) ? DW * (SHARES - 1) : DW;

  logic [c_RW-1:0] r_rnd;
  logic [c_W-1:0]  w_rnd_ext;
  logic [7:0]      w_rnd_all;

  always_comb begin
    w_rnd_all = 8'h00;
    for (int k = 0; k < SHARES - 1; k++) w_rnd_all ^= r_rnd[8*k +: 8];
  end

  // Top byte of the extension is zero; the last share uses w_rnd_all instead.
  assign w_rnd_ext = c_W'(r_rnd);
  assign w_fin     = w_mapped ^ (w_last ? w_rnd_all : 8'h00);
`else
  assign w_fin     = w_mapped;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_in_data  <= '0;
      r_out_data <= '0;
      r_inv      <= 1'b0;
`ifdef LIN_MAP_REFRESH_EN
      r_rnd      <= '0;
`endif
    end else if (w_accept) begin
      r_idx     <= '0;
      r_in_data <= bus.in_data;
      r_inv     <= bus.inv_i;
`ifdef LIN_MAP_REFRESH_EN
      r_rnd     <= bus.rnd_i;
`endif
    end else if (r_state == ST_BUSY) begin
      r_idx <= (r_idx == c_LAST) ? '0 : r_idx + c_IW'(1);
      for (int k = 0; k < SHARES; k++) begin
        if (r_idx == c_IW'(k)) begin
          r_out_data[8*k +: 8] <= w_fin;
`ifdef LIN_MAP_REFRESH_EN
        end else if (w_last) begin
          r_out_data[8*k +: 8] <= r_out_data[8*k +: 8] ^ w_rnd_ext[8*k +: 8];
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire
